// File: rtl/coord_dispatcher_if.sv
// Dispatcher-side bundle: frame control, shared engine dispatch/result bus
// and the pixel result stream. The dispatcher connects as master.
interface coord_dispatcher_if #(
    parameter int NUM_ENGINES = 8
);
    logic                   start;
    logic [31:0]            re_start;
    logic [31:0]            im_start;
    logic [31:0]            re_step;
    logic [31:0]            im_step;
    logic [NUM_ENGINES-1:0] available;
    logic [NUM_ENGINES-1:0] service_req;
    logic [26:0]            out_word;
    logic [2:0]             engine_addr;
    logic [82:0]            in_word;
    logic                   latch_en;
    logic [NUM_ENGINES-1:0] req_ack;
    logic                   pix_valid;
    logic [9:0]             pix_x;
    logic [8:0]             pix_y;
    logic [7:0]             pix_iter;
    logic                   pix_ready;
    logic                   busy;
    logic                   frame_done;

    modport master (
        input  start, re_start, im_start, re_step, im_step,
        input  available, service_req, out_word, pix_ready,
        output engine_addr, in_word, latch_en, req_ack,
        output pix_valid, pix_x, pix_y, pix_iter, busy, frame_done
    );

    modport slave (
        output start, re_start, im_start, re_step, im_step,
        output available, service_req, out_word, pix_ready,
        input  engine_addr, in_word, latch_en, req_ack,
        input  pix_valid, pix_x, pix_y, pix_iter, busy, frame_done
    );
endinterface

// File: rtl/coord_dispatcher.sv
// Frame-level master for the Mandelbrot engine array: scans the raster,
// dispatches pixels to idle engines and streams collected results out.
module coord_dispatcher #(
    parameter int NUM_ENGINES = 8,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480
) (
    input  logic               Engine_CLK,
    input  logic               eRST,
    coord_dispatcher_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        DISP  = 3'd2,
        DWAIT = 3'd3,
        ACK   = 3'd4,
        RWAIT = 3'd5,
        PUSH  = 3'd6
    } state_t;

    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

    // Returns {found, index} of the lowest set bit.
    function automatic logic [3:0] lowest_idx(input logic [NUM_ENGINES-1:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (v[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    function automatic logic [NUM_ENGINES-1:0] onehot(input logic [2:0] idx);
        logic [NUM_ENGINES-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (3'(i) == idx) r[i] = 1'b1;
        end
        return r;
    endfunction

    state_t                 state_q;
    logic [31:0]            re_start_q, re_step_q, im_step_q;
    logic [31:0]            cur_re_q, cur_im_q;
    logic [9:0]             x_q;
    logic [8:0]             y_q;
    logic                   scan_done_q;
    logic [3:0]             outstanding_q;
    logic [2:0]             sel_q;
    logic [2:0]             engine_addr_q;
    logic [82:0]            in_word_q;
    logic                   latch_en_q;
    logic [NUM_ENGINES-1:0] req_ack_q;
    logic                   pix_valid_q;
    logic [9:0]             pix_x_q;
    logic [8:0]             pix_y_q;
    logic [7:0]             pix_iter_q;
    logic                   busy_q;
    logic                   frame_done_q;

    logic [3:0] svc_pick_s;
    logic [3:0] avl_pick_s;

    assign svc_pick_s = lowest_idx(bus.service_req);
    assign avl_pick_s = lowest_idx(bus.available);

    // Dispatcher FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge Engine_CLK) begin
        if (eRST) begin
            state_q       <= IDLE;
            re_start_q    <= 32'd0;
            re_step_q     <= 32'd0;
            im_step_q     <= 32'd0;
            cur_re_q      <= 32'd0;
            cur_im_q      <= 32'd0;
            x_q           <= 10'd0;
            y_q           <= 9'd0;
            scan_done_q   <= 1'b0;
            outstanding_q <= 4'd0;
            sel_q         <= 3'd0;
            engine_addr_q <= 3'd0;
            in_word_q     <= 83'd0;
            latch_en_q    <= 1'b0;
            req_ack_q     <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 9'd0;
            pix_iter_q    <= 8'd0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        re_start_q    <= bus.re_start;
                        re_step_q     <= bus.re_step;
                        im_step_q     <= bus.im_step;
                        cur_re_q      <= bus.re_start;
                        cur_im_q      <= bus.im_start;
                        x_q           <= 10'd0;
                        y_q           <= 9'd0;
                        scan_done_q   <= 1'b0;
                        outstanding_q <= 4'd0;
                        busy_q        <= 1'b1;
                        state_q       <= ARB;
                    end
                end
                ARB: begin
                    if (svc_pick_s[3]) begin
                        sel_q     <= svc_pick_s[2:0];
                        req_ack_q <= onehot(svc_pick_s[2:0]);
                        state_q   <= ACK;
                    end else if (!scan_done_q && avl_pick_s[3]) begin
                        sel_q         <= avl_pick_s[2:0];
                        engine_addr_q <= avl_pick_s[2:0];
                        in_word_q     <= {x_q, y_q, cur_re_q, cur_im_q};
                        latch_en_q    <= 1'b1;
                        state_q       <= DISP;
                    end else if (scan_done_q && (outstanding_q == 4'd0)) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                DISP: begin
                    latch_en_q    <= 1'b0;
                    outstanding_q <= outstanding_q + 4'd1;
                    if (x_q == X_LAST) begin
                        x_q      <= 10'd0;
                        cur_re_q <= re_start_q;
                        cur_im_q <= cur_im_q + im_step_q;
                        if (y_q == Y_LAST) begin
                            scan_done_q <= 1'b1;
                        end else begin
                            y_q <= y_q + 9'd1;
                        end
                    end else begin
                        x_q      <= x_q + 10'd1;
                        cur_re_q <= cur_re_q + re_step_q;
                    end
                    state_q <= DWAIT;
                end
                DWAIT: begin
                    // Hold off re-arbitration until the engine shows it has latched.
                    if (!bus.available[sel_q]) state_q <= ARB;
                end
                ACK: begin
                    req_ack_q  <= '0;
                    pix_x_q    <= bus.out_word[26:17];
                    pix_y_q    <= bus.out_word[16:8];
                    pix_iter_q <= bus.out_word[7:0];
                    state_q    <= RWAIT;
                end
                RWAIT: begin
                    if (!bus.service_req[sel_q]) begin
                        pix_valid_q <= 1'b1;
                        state_q     <= PUSH;
                    end
                end
                PUSH: begin
                    if (bus.pix_ready) begin
                        pix_valid_q   <= 1'b0;
                        outstanding_q <= outstanding_q - 4'd1;
                        state_q       <= ARB;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.engine_addr = engine_addr_q;
    assign bus.in_word     = in_word_q;
    assign bus.latch_en    = latch_en_q;
    assign bus.req_ack     = req_ack_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_iter    = pix_iter_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_coord_dispatcher.sv
// Directed bench for coord_dispatcher on a 4x2 raster: manual arbitration and
// back-pressure steps, mid-frame reset, then a full frame against an engine model.
module tb_coord_dispatcher;
    localparam int NE = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coord_dispatcher_if #(.NUM_ENGINES(NE)) bus ();

    coord_dispatcher #(.NUM_ENGINES(NE), .WIDTH(4), .HEIGHT(2)) dut (
        .Engine_CLK (clk),
        .eRST       (rst),
        .bus        (bus.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [82:0] obs, input logic [82:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Engine environment: manual drive or a behavioural engine array
    logic          manual;
    logic [NE-1:0] man_avail, man_svc, eng_en;
    logic [26:0]   man_word [NE];
    logic [NE-1:0] m_busy, m_svc;
    logic [2:0]    m_cnt [NE];
    logic [26:0]   m_res [NE];

    function automatic logic [7:0] iter_of(input logic [9:0] x, input logic [8:0] y);
        return (x[7:0] + {y[5:0], 2'b00}) ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NE; k++) begin
            if (rst || manual) begin
                m_busy[k] <= 1'b0;
                m_svc[k]  <= 1'b0;
                m_cnt[k]  <= 3'd0;
            end else begin
                if (bus.latch_en && bus.engine_addr == 3'(k) && eng_en[k] && !m_busy[k]) begin
                    m_busy[k] <= 1'b1;
                    m_cnt[k]  <= 3'd3;
                    m_res[k]  <= {bus.in_word[82:73], bus.in_word[72:64],
                                  iter_of(bus.in_word[82:73], bus.in_word[72:64])};
                end else if (m_busy[k] && !m_svc[k]) begin
                    if (m_cnt[k] == 3'd0) m_svc[k] <= 1'b1;
                    else m_cnt[k] <= m_cnt[k] - 3'd1;
                end
                if (bus.req_ack[k]) begin
                    m_svc[k]  <= 1'b0;
                    m_busy[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.available   = manual ? man_avail : (eng_en & ~m_busy);
        bus.service_req = manual ? man_svc : m_svc;
        bus.out_word    = 27'd0;
        for (int k = 0; k < NE; k++) begin
            if (bus.req_ack[k]) bus.out_word = manual ? man_word[k] : m_res[k];
        end
    end

    // Monitor: records dispatches, accepted pixels, frame_done pulses and bus-rule violations
    logic [82:0] disp_word [64];
    logic [2:0]  disp_addr [64];
    logic [26:0] pix_rec [64];
    int disp_n = 0;
    int pix_n  = 0;
    int fd_n   = 0;
    int viol   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.latch_en) begin
                if (disp_n < 64) begin
                    disp_word[disp_n] = bus.in_word;
                    disp_addr[disp_n] = bus.engine_addr;
                end
                disp_n++;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (pix_n < 64) pix_rec[pix_n] = {bus.pix_x, bus.pix_y, bus.pix_iter};
                pix_n++;
            end
            if (bus.frame_done) fd_n++;
            if (bus.latch_en && (bus.req_ack != '0)) viol++;
            if (!$onehot0(bus.req_ack)) viol++;
        end
    end

    initial begin
        int dn0, pn0, fd0;
        logic [82:0] exp_w;
        logic [31:0] re_e, im_e;

        bus.start = 1'b0;
        bus.re_start = 32'd0;
        bus.im_start = 32'd0;
        bus.re_step = 32'd0;
        bus.im_step = 32'd0;
        bus.pix_ready = 1'b1;
        manual = 1'b1;
        man_avail = '0;
        man_svc = '0;
        eng_en = '0;
        for (int k = 0; k < NE; k++) man_word[k] = 27'd0;

        rst = 1'b1;
        step(2);
        chk("rst_busy", 83'(bus.busy), 83'd0);
        chk("rst_latch_en", 83'(bus.latch_en), 83'd0);
        chk("rst_req_ack", 83'(bus.req_ack), 83'd0);
        chk("rst_in_word", bus.in_word, 83'd0);
        chk("rst_pix", 83'({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_iter, bus.engine_addr}), 83'd0);
        chk("rst_frame_done", 83'(bus.frame_done), 83'd0);
        rst = 1'b0;

        // Manual arbitration: engines 2 and 5 request together
        bus.re_start = 32'hFE000000;
        bus.im_start = 32'h01000000;
        bus.re_step  = 32'h00100000;
        bus.im_step  = 32'hFF800000;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_busy", 83'(bus.busy), 83'd1);
        step(2);
        chk("no_avail_no_disp", 83'(bus.latch_en), 83'd0);
        man_word[2] = {10'd1, 9'd2, 8'h33};
        man_word[5] = {10'd7, 9'd6, 8'hC4};
        dn0 = disp_n;
        man_svc = 8'h24;
        man_avail = 8'hFF;
        step();
        chk("ack_eng2_first", 83'(bus.req_ack), 83'h04);
        chk("ack2_no_latch", 83'(bus.latch_en), 83'd0);
        step();
        chk("ack2_one_cycle", 83'(bus.req_ack), 83'd0);
        man_svc = 8'h20;
        step();
        chk("pix_eng2", 83'({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_iter}), 83'({1'b1, 10'd1, 9'd2, 8'h33}));
        step();
        chk("pix_eng2_taken", 83'(bus.pix_valid), 83'd0);
        step();
        chk("ack_eng5", 83'(bus.req_ack), 83'h20);
        chk("ack5_no_latch", 83'(bus.latch_en), 83'd0);
        step();
        man_svc = 8'h00;
        bus.pix_ready = 1'b0;
        step();
        chk("pix_eng5", 83'({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_iter}), 83'({1'b1, 10'd7, 9'd6, 8'hC4}));
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_hold", 83'({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_iter, bus.req_ack, bus.latch_en}),
                83'({1'b1, 10'd7, 9'd6, 8'hC4, 8'h00, 1'b0}));
        end
        chk("no_disp_while_req", 83'(disp_n - dn0), 83'd0);
        bus.pix_ready = 1'b1;
        step();
        chk("stall_release", 83'(bus.pix_valid), 83'd0);
        step();
        chk("resume_latch", 83'({bus.latch_en, bus.engine_addr}), 83'({1'b1, 3'd0}));
        chk("resume_in_word", bus.in_word, {10'd0, 9'd0, 32'hFE000000, 32'h01000000});

        // Reset in the middle of the frame
        fd0 = fd_n;
        rst = 1'b1;
        step();
        chk("midrst_outs", 83'({bus.latch_en, bus.req_ack, bus.engine_addr, bus.pix_valid,
                                bus.pix_x, bus.pix_y, bus.pix_iter, bus.busy, bus.frame_done}), 83'd0);
        chk("midrst_in_word", bus.in_word, 83'd0);
        rst = 1'b0;
        man_avail = '0;
        step(3);
        chk("midrst_no_done", 83'(fd_n - fd0), 83'd0);
        chk("midrst_idle", 83'(bus.busy), 83'd0);

        // Full frame against one engine, with an ignored start mid-frame
        manual = 1'b0;
        eng_en = 8'h01;
        dn0 = disp_n;
        pn0 = pix_n;
        fd0 = fd_n;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("frame_busy", 83'(bus.busy), 83'd1);
        step(5);
        bus.re_start = 32'h12345678;
        bus.im_start = 32'h0BADF00D;
        bus.re_step  = 32'h00000001;
        bus.im_step  = 32'h00000002;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 600 && fd_n == fd0; i++) step();
        chk("frame_done_seen", 83'(fd_n - fd0), 83'd1);
        step(3);
        chk("frame_done_once", 83'(fd_n - fd0), 83'd1);
        chk("frame_idle", 83'(bus.busy), 83'd0);
        chk("disp_count", 83'(disp_n - dn0), 83'd8);
        chk("pix_count", 83'(pix_n - pn0), 83'd8);
        if (disp_n - dn0 >= 8 && dn0 + 8 <= 64) begin
            chk("re_x2", 83'(disp_word[dn0 + 2][63:32]), 83'(32'hFE200000));
            chk("re_line1_x0", 83'(disp_word[dn0 + 4][63:32]), 83'(32'hFE000000));
            chk("y_after_wrap", 83'(disp_word[dn0 + 4][72:64]), 83'd1);
            for (int i = 0; i < 8; i++) begin
                re_e = 32'hFE000000 + 32'(i % 4) * 32'h00100000;
                im_e = 32'h01000000 + 32'(i / 4) * 32'hFF800000;
                exp_w = {10'(i % 4), 9'(i / 4), re_e, im_e};
                chk("disp_word", disp_word[dn0 + i], exp_w);
                chk("disp_addr", 83'(disp_addr[dn0 + i]), 83'd0);
            end
        end
        if (pix_n - pn0 >= 8 && pn0 + 8 <= 64) begin
            for (int i = 0; i < 8; i++) begin
                chk("pix_beat", 83'(pix_rec[pn0 + i]), 83'({10'(i % 4), 9'(i / 4), 8'(i) ^ 8'hA5}));
            end
        end
        chk("bus_rules", 83'(viol), 83'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
